// File: rtl/reservoir_readout.sv
// reservoir_readout: per-node weighted readout of a reservoir sample stream.
// Each frame of VIRTUAL_NODES samples is multiplied against a programmable
// weight file, accumulated at full precision and emitted as one fixed-point
// prediction.
// Optional build macro: READOUT_SAT_EN -- when defined, the scaled result
// saturates to the signed DATA_WIDTH range; otherwise it wraps (keeps low bits).
module reservoir_readout #(
    parameter  int VIRTUAL_NODES = 10,
    parameter  int DATA_WIDTH    = 32,
    parameter  int FRAC_BITS     = 16,
    localparam int AW            = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1,
    localparam int ACC_W         = 2 * DATA_WIDTH + AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  weight_we,
    input  logic [AW-1:0]         weight_addr,
    input  logic [DATA_WIDTH-1:0] weight_data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [AW-1:0]         node_idx,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    // Node count widened by one bit so that a full power-of-two count still fits.
    localparam logic [AW:0]   NODES_W  = (AW + 1)'(VIRTUAL_NODES);
    localparam logic [AW-1:0] LAST_IDX = AW'(VIRTUAL_NODES - 1);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ACC_W-1:0]        r_acc;
    logic [AW-1:0]           r_node_idx;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_dout_valid;
    logic                    r_overrun;
    logic                    r_din_ready;
    logic [DATA_WIDTH-1:0]   r_weight [VIRTUAL_NODES];

    logic                          w_accept;
    logic                          w_addr_ok;
    logic [DATA_WIDTH-1:0]         w_weight_sel;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic [ACC_W-1:0]              w_prod_ext;

    // Arithmetic right shift (floor) by FRAC_BITS, then reduce to DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] scale_result(input logic signed [ACC_W-1:0] a);
`ifdef READOUT_SAT_EN
        logic signed [ACC_W-1:0] sh;
        sh = a >>> FRAC_BITS;
        // In range when every bit above the result sign bit equals that sign bit.
        if ((&sh[ACC_W-1:DATA_WIDTH-1]) || (~|sh[ACC_W-1:DATA_WIDTH-1])) begin
            return sh[DATA_WIDTH-1:0];
        end else if (sh[ACC_W-1]) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`else
        return DATA_WIDTH'(a >>> FRAC_BITS);
`endif
    endfunction

    assign w_accept     = din_valid && (r_state != ST_EMIT);
    assign w_addr_ok    = ({1'b0, weight_addr} < NODES_W);
    // The MAC reads the weight register before any same-cycle write lands,
    // so a simultaneous write to the active node only affects later frames.
    assign w_weight_sel = r_weight[r_node_idx];
    assign w_prod       = $signed(din) * $signed(w_weight_sel);
    assign w_prod_ext   = {{AW{w_prod[2*DATA_WIDTH-1]}}, w_prod};

    assign din_ready  = r_din_ready;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign node_idx   = r_node_idx;
    assign overrun    = r_overrun;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: collect a frame, then spend one cycle emitting it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (VIRTUAL_NODES == 32'sd1) begin
                        w_state_next = ST_EMIT;
                    end else begin
                        w_state_next = ST_ACCUM;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_accept && (r_node_idx == LAST_IDX)) begin
                    w_state_next = ST_EMIT;
                end else begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_EMIT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Ready flag registered from the next state so it tracks state != EMIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_din_ready <= 1'b1;
        end else begin
            r_din_ready <= (w_state_next != ST_EMIT);
        end
    end

    // Multiply-accumulate datapath, result scaling and output pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc        <= {ACC_W{1'b0}};
            r_node_idx   <= {AW{1'b0}};
            r_dout       <= {DATA_WIDTH{1'b0}};
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc      <= w_prod_ext;
                        r_node_idx <= ONE_IDX;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc      <= r_acc + w_prod_ext;
                        r_node_idx <= r_node_idx + ONE_IDX;
                    end
                end
                ST_EMIT: begin
                    r_dout       <= scale_result($signed(r_acc));
                    r_dout_valid <= 1'b1;
                    r_acc        <= {ACC_W{1'b0}};
                    r_node_idx   <= {AW{1'b0}};
                end
                default: begin
                    r_acc      <= {ACC_W{1'b0}};
                    r_node_idx <= {AW{1'b0}};
                end
            endcase
        end
    end

    // Sticky overrun: a sample offered while the emit cycle blocks input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (din_valid && (r_state == ST_EMIT)) begin
            r_overrun <= 1'b1;
        end
    end

    // Weight register file; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < VIRTUAL_NODES; i++) begin
                r_weight[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (weight_we && w_addr_ok) begin
            r_weight[weight_addr] <= weight_data;
        end
    end

endmodule

// File: tb/tb_reservoir_readout.sv
// Testbench for reservoir_readout (VIRTUAL_NODES=10, DATA_WIDTH=32, FRAC_BITS=16).
// Table of uniform-weight frames plus hand-written multi-cycle sequences;
// expected predictions go through a scoreboard queue.
module tb_reservoir_readout;

    localparam int VN = 10;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          weight_we;
    logic [AW-1:0] weight_addr;
    logic [DW-1:0] weight_data;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [AW-1:0] node_idx;
    logic          overrun;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;
    logic [DW-1:0] sb [$];

    typedef struct {
        string         name;
        logic [DW-1:0] w;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    reservoir_readout #(
        .VIRTUAL_NODES(VN),
        .DATA_WIDTH   (DW),
        .FRAC_BITS    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .weight_we  (weight_we),
        .weight_addr(weight_addr),
        .weight_data(weight_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .node_idx   (node_idx),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count output pulses, sampled on the inactive edge.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic load_weights(input logic [DW-1:0] w);
        din_valid = 1'b0;
        for (int i = 0; i < VN; i++) begin
            weight_we   = 1'b1;
            weight_addr = 4'(i);
            weight_data = w;
            tick();
        end
        weight_we = 1'b0;
    endtask

    // Wait (bounded) for the pulse after the last accept; check latency, value, pulse count.
    task automatic wait_result(input string name, input int p0);
        int n;
        bit found;
        logic [DW-1:0] exp;
        n = 0;
        found = 1'b0;
        while (n < 4 && !found) begin
            tick();
            n++;
            if (dout_valid === 1'b1) found = 1'b1;
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 32'h0;
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_pulse required=pulse", name);
        end else begin
            chk({name, "_latency"}, 32'(n), 32'd1);
            chk({name, "_dout"}, dout, exp);
        end
        tick();
        chk({name, "_pulses"}, 32'(pulse_cnt - p0), 32'd1);
        chk({name, "_hold"}, dout, exp);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic [DW-1:0] exp, input string name);
        int p0;
        p0 = pulse_cnt;
        for (int i = 0; i < VN; i++) begin
            din       = d;
            din_valid = 1'b1;
            if (i == VN - 1) sb.push_back(exp);
            tick();
        end
        din_valid = 1'b0;
        chk({name, "_ready_emit"}, 32'(din_ready), 32'd0);
        wait_result(name, p0);
    endtask

    initial begin
        int p0;
        vecs[0] = '{"unity",  32'h0001_0000, 32'h0001_0000, 32'h000A_0000};
        vecs[1] = '{"neg",    32'hFFFF_0000, 32'h0002_0000, 32'hFFEC_0000};
        vecs[2] = '{"half",   32'h0000_8000, 32'h0003_0000, 32'h000F_0000};
        vecs[3] = '{"floor",  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
`ifdef READOUT_SAT_EN
        vecs[4] = '{"bigpos", 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF};
        vecs[5] = '{"bigneg", 32'h8000_0000, 32'h7FFF_0000, 32'h8000_0000};
`else
        vecs[4] = '{"bigpos", 32'h7FFF_0000, 32'h7FFF_0000, 32'h000A_0000};
        vecs[5] = '{"bigneg", 32'h8000_0000, 32'h7FFF_0000, 32'h0000_0000};
`endif

        rst = 1'b0;
        din = 32'h0;
        din_valid = 1'b0;
        weight_we = 1'b0;
        weight_addr = 4'h0;
        weight_data = 32'h0;
        tick();
        tick();
        rst = 1'b1;
        chk("rst_dout", dout, 32'h0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_node_idx", 32'(node_idx), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_ready", 32'(din_ready), 32'd1);

        // Table-driven uniform-weight frames.
        for (int k = 0; k < 6; k++) begin
            load_weights(vecs[k].w);
            send_frame(vecs[k].d, vecs[k].exp, vecs[k].name);
        end

        // Distinct weights per node: w[i]=(i+1).0, din[i]=(i-4)*0.5 -> sum 55.0.
        for (int i = 0; i < VN; i++) begin
            weight_we   = 1'b1;
            weight_addr = 4'(i);
            weight_data = 32'(i + 1) << 16;
            tick();
        end
        weight_we = 1'b0;
        p0 = pulse_cnt;
        for (int i = 0; i < VN; i++) begin
            din       = 32'(i - 4) << 15;
            din_valid = 1'b1;
            chk("mixed_node_idx", 32'(node_idx), 32'(i));
            if (i == VN - 1) sb.push_back(32'h0037_0000);
            tick();
        end
        din_valid = 1'b0;
        wait_result("mixed", p0);

        // Held din_valid for 11 cycles: the 11th sample hits EMIT and sets overrun.
        load_weights(32'h0001_0000);
        chk("pre_overrun", 32'(overrun), 32'd0);
        p0 = pulse_cnt;
        for (int i = 0; i < VN; i++) begin
            din       = 32'h0001_0000;
            din_valid = 1'b1;
            if (i == VN - 1) sb.push_back(32'h000A_0000);
            tick();
        end
        tick();
        din_valid = 1'b0;
        chk("ovr_valid", 32'(dout_valid), 32'd1);
        chk("ovr_dout", dout, sb.pop_front());
        chk("ovr_overrun", 32'(overrun), 32'd1);
        chk("ovr_node_idx", 32'(node_idx), 32'd0);
        tick();
        chk("ovr_ready", 32'(din_ready), 32'd1);
        chk("ovr_idle_idx", 32'(node_idx), 32'd0);
        chk("ovr_pulses", 32'(pulse_cnt - p0), 32'd1);
        send_frame(32'h0001_0000, 32'h000A_0000, "after_ovr");
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset mid-frame: partial frame discarded, weights cleared.
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            din       = 32'h0001_0000;
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        chk("mid_node_idx", 32'(node_idx), 32'd5);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_dout", dout, 32'h0);
        chk("mrst_node_idx", 32'(node_idx), 32'd0);
        chk("mrst_overrun", 32'(overrun), 32'd0);
        tick();
        tick();
        chk("mrst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        send_frame(32'h0001_0000, 32'h0000_0000, "zero_w");

        // Out-of-range weight address must not alias onto a real node.
        weight_we   = 1'b1;
        weight_addr = 4'd12;
        weight_data = 32'h0001_0000;
        tick();
        weight_we = 1'b0;
        send_frame(32'h0001_0000, 32'h0000_0000, "addr12");

        // Write node 3 while its sample is being accumulated: old weight used.
        load_weights(32'h0001_0000);
        p0 = pulse_cnt;
        for (int i = 0; i < VN; i++) begin
            din         = 32'h0001_0000;
            din_valid   = 1'b1;
            weight_we   = (i == 3);
            weight_addr = 4'd3;
            weight_data = 32'h0002_0000;
            if (i == VN - 1) sb.push_back(32'h000A_0000);
            tick();
        end
        din_valid = 1'b0;
        weight_we = 1'b0;
        wait_result("wr_same", p0);
        send_frame(32'h0001_0000, 32'h000B_0000, "wr_next");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
